// File: rtl/c8_count_seq.sv
// c8_count_seq: registered load/decrement counter with valid/ready parallel load and terminal-count pulse.
// Optional feature macro: C8_AUTO_RELOAD_EN (auto-reload of the last handshake value after each terminal count).
module c8_count_seq #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             load_valid_pad,
  output logic             load_ready_pad,
  input  logic             src_sel_pad,
  input  logic [WIDTH-1:0] bank_a_pad,
  input  logic [WIDTH-1:0] bank_b_pad,
  input  logic             count_en_pad,
  input  logic             abort_pad,
  output logic [WIDTH-1:0] count_pad,
  output logic             busy_pad,
  output logic             tc_pad
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]       PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       presc_q, presc_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] load_word;
  logic             handshake;

`ifdef C8_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_word = src_sel_pad ? bank_b_pad : bank_a_pad;
  // ready is registered so it stays low until the first edge after reset release.
  assign handshake = load_valid_pad && ready_q && !abort_pad;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
`ifdef C8_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          count_d = load_word;
          presc_d = '0;
          state_d = S_LOAD;
`ifdef C8_AUTO_RELOAD_EN
          reload_d = load_word;
`endif
        end
      end

      S_LOAD: begin
        presc_d = '0;
        state_d = (count_q == '0) ? S_DONE : S_COUNT;
      end

      S_COUNT: begin
        if (count_en_pad) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            // Saturate at zero; the 1->0 step is the terminal one.
            if (count_q != '0) count_d = count_q - ONE;
            if (count_q <= ONE) state_d = S_DONE;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end

      S_DONE: begin
`ifdef C8_AUTO_RELOAD_EN
        count_d = reload_q;
        presc_d = '0;
        state_d = S_LOAD;
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: count word holds, prescaler clears.
    if (abort_pad) begin
      state_d = S_IDLE;
      count_d = count_q;
      presc_d = '0;
`ifdef C8_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
    end

    ready_d = (state_d == S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      state_q <= S_IDLE;
      count_q <= '0;
      presc_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      ready_q <= ready_d;
    end
  end

`ifdef C8_AUTO_RELOAD_EN
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) reload_q <= '0;
    else            reload_q <= reload_d;
  end
`endif

  assign load_ready_pad = ready_q;
  assign count_pad      = count_q;
  assign busy_pad       = (state_q == S_LOAD) || (state_q == S_COUNT);
  assign tc_pad         = (state_q == S_DONE) && !abort_pad;

endmodule
